// File: rtl/simple_spi_slave_pkg.sv
// Shared types and register layout for the SPI responder core.
package simple_spi_slave_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] CFG_OFF = 8'd0;
    localparam logic [7:0] TX_OFF  = 8'd1;

    localparam int CFG_DATAIN_EDGE  = 6;
    localparam int CFG_DATAOUT_EDGE = 7;
    localparam int CFG_CLEAR_ERROR  = 8;

    // A programmed length of zero means a full 32-bit word.
    function automatic logic [5:0] eff_num_bits(input logic [5:0] raw);
        return (raw == 6'd0) ? 6'd32 : raw;
    endfunction

endpackage

// File: rtl/setting_reg.sv
// Addressed settings register: loads on a matching strobe, pulses changed for one cycle.
module setting_reg #(
    parameter logic [7:0]  ADDR     = 8'd0,
    parameter logic [31:0] AT_RESET = 32'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        strobe,
    input  logic [7:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        changed
);

    always_ff @(posedge clock) begin
        if (reset) begin
            data_out <= AT_RESET;
            changed  <= 1'b0;
        end else if (strobe && (addr == ADDR)) begin
            data_out <= data_in;
            changed  <= 1'b1;
        end else begin
            changed  <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_slave_sync.sv
// Two-flop synchronizer plus a history flop giving single-cycle rise/fall pulses.
module spi_slave_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [2:0] pipe;

    always_ff @(posedge clock) begin
        if (reset) pipe <= {3{RESET_VAL}};
        else       pipe <= {pipe[1:0], async_in};
    end

    assign sync_out = pipe[1];
    assign rise     = pipe[1] & ~pipe[2];
    assign fall     = ~pipe[1] & pipe[2];

endmodule

// File: rtl/simple_spi_slave_core.sv
// SPI responder in the system clock domain: oversampled sen/sclk/mosi, preloaded tx word.
// Optional debug bus enabled by defining SIMPLE_SPI_SLAVE_DEBUG_EN.
import simple_spi_slave_pkg::*;

// state  | meaning
// IDLE   | waiting for sen to go active, miso tristated
// ACTIVE | frame in progress, sampling and shifting on sclk edges
// DONE   | one cycle: publish readback or flag a short/long frame
module simple_spi_slave_core #(
    parameter int   BASE       = 0,
    parameter logic CLK_IDLE   = 1'b0,
    parameter logic SEN_ACTIVE = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    output logic [31:0] readback,
    output logic        rx_stb,
    output logic        busy,
    output logic        error,
    input  logic        sen,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic [31:0] debug
);

    logic [31:0] cfg, tx_pending;
    logic        cfg_changed, tx_changed;
    logic        sen_s, sen_rise, sen_fall;
    logic        sclk_s, sclk_rise, sclk_fall;
    logic        mosi_s, mosi_rise, mosi_fall;

    setting_reg #(.ADDR(8'(BASE) + CFG_OFF)) u_cfg_reg (
        .clock(clock), .reset(reset), .strobe(set_stb), .addr(set_addr),
        .data_in(set_data), .data_out(cfg), .changed(cfg_changed)
    );

    setting_reg #(.ADDR(8'(BASE) + TX_OFF)) u_tx_reg (
        .clock(clock), .reset(reset), .strobe(set_stb), .addr(set_addr),
        .data_in(set_data), .data_out(tx_pending), .changed(tx_changed)
    );

    spi_slave_sync #(.RESET_VAL(~SEN_ACTIVE)) u_sync_sen (
        .clock(clock), .reset(reset), .async_in(sen),
        .sync_out(sen_s), .rise(sen_rise), .fall(sen_fall)
    );

    spi_slave_sync #(.RESET_VAL(CLK_IDLE)) u_sync_sclk (
        .clock(clock), .reset(reset), .async_in(sclk),
        .sync_out(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_slave_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clock(clock), .reset(reset), .async_in(mosi),
        .sync_out(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    state_t      state, state_d;
    logic [31:0] tx_shift, tx_shift_d, rx_shift, rx_shift_d, readback_d;
    logic [5:0]  bit_cnt, bit_cnt_d, cnt_after, num_bits;
    logic        long_flag, long_flag_d, error_d, rx_stb_d;
    logic        start_pend, start_pend_d;
    logic        sample_edge, drive_edge, sen_start, sen_on, clear_error;

    assign num_bits    = eff_num_bits(cfg[5:0]);
    assign sample_edge = cfg[CFG_DATAIN_EDGE]  ? sclk_rise : sclk_fall;
    assign drive_edge  = cfg[CFG_DATAOUT_EDGE] ? sclk_rise : sclk_fall;
    assign sen_start   = SEN_ACTIVE ? sen_rise : sen_fall;
    assign sen_on      = (sen_s == SEN_ACTIVE);
    assign clear_error = cfg_changed & cfg[CFG_CLEAR_ERROR];

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d      = state;
        tx_shift_d   = tx_shift;
        rx_shift_d   = rx_shift;
        bit_cnt_d    = bit_cnt;
        long_flag_d  = long_flag;
        readback_d   = readback;
        rx_stb_d     = 1'b0;
        error_d      = error & ~clear_error;
        start_pend_d = 1'b0;
        cnt_after    = bit_cnt;
        case (state)
            IDLE: begin
                bit_cnt_d   = 6'd0;
                long_flag_d = 1'b0;
                if (sen_start || start_pend) begin
                    tx_shift_d = tx_pending;
                    rx_shift_d = 32'd0;
                    state_d    = ACTIVE;
                end
            end
            ACTIVE: begin
                if (sample_edge) begin
                    if (bit_cnt < num_bits) begin
                        rx_shift_d = {rx_shift[30:0], mosi_s};
                        cnt_after  = bit_cnt + 6'd1;
                    end else begin
                        long_flag_d = 1'b1;
                    end
                end
                // Uses the post-sample count so a same-edge config samples before shifting.
                if (drive_edge && (cnt_after != 6'd0) && (cnt_after < num_bits))
                    tx_shift_d = {tx_shift[30:0], 1'b0};
                bit_cnt_d = cnt_after;
                if (!sen_on) state_d = DONE;
            end
            DONE: begin
                if ((bit_cnt == num_bits) && !long_flag) begin
                    readback_d = rx_shift;
                    rx_stb_d   = 1'b1;
                end else begin
                    error_d = 1'b1;
                end
                start_pend_d = sen_start;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_shift   <= 32'd0;
            rx_shift   <= 32'd0;
            bit_cnt    <= 6'd0;
            long_flag  <= 1'b0;
            readback   <= 32'd0;
            rx_stb     <= 1'b0;
            error      <= 1'b0;
            start_pend <= 1'b0;
        end else begin
            tx_shift   <= tx_shift_d;
            rx_shift   <= rx_shift_d;
            bit_cnt    <= bit_cnt_d;
            long_flag  <= long_flag_d;
            readback   <= readback_d;
            rx_stb     <= rx_stb_d;
            error      <= error_d;
            start_pend <= start_pend_d;
        end
    end

    assign busy    = (state != IDLE);
    assign miso_oe = (state == ACTIVE);
    assign miso    = (state == ACTIVE) ? tx_shift[31] : 1'b0;

`ifdef SIMPLE_SPI_SLAVE_DEBUG_EN
    logic [7:0] frame_cnt;
    logic [1:0] state_bits;

    assign state_bits = state;

    always_ff @(posedge clock) begin
        if (reset)         frame_cnt <= 8'd0;
        else if (rx_stb_d) frame_cnt <= frame_cnt + 8'd1;
    end

    assign debug = {2'b00, state_bits, sen_s, sclk_s, mosi_s, miso, busy, error,
                    bit_cnt, frame_cnt, cfg[5:0], 2'b00};
`else
    assign debug = 32'h0;
`endif

    logic unused_bits;
    assign unused_bits = ^{cfg[31:9], tx_changed, mosi_rise, mosi_fall, sclk_s};

endmodule

// File: tb/tb_simple_spi_slave_core.sv
// Directed + randomized frames against a bit-level model of the SPI responder.
`timescale 1ns/1ps
module tb_simple_spi_slave_core;
    import simple_spi_slave_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = 8'd0;
    logic [31:0] set_data = 32'd0;
    logic [31:0] readback, debug;
    logic        rx_stb, busy, error, miso, miso_oe;
    logic        sen = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;

    int total = 0;
    int bad = 0;
    int rx_cnt = 0;

    logic [31:0] tx_pend = 32'd0;
    logic [31:0] exp_rb = 32'd0;
    logic        exp_err = 1'b0;

    simple_spi_slave_core dut (
        .clock(clock), .reset(reset), .set_stb(set_stb), .set_addr(set_addr),
        .set_data(set_data), .readback(readback), .rx_stb(rx_stb), .busy(busy),
        .error(error), .sen(sen), .sclk(sclk), .mosi(mosi), .miso(miso),
        .miso_oe(miso_oe), .debug(debug)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (rx_stb) rx_cnt <= rx_cnt + 1;

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input logic [7:0] addr, input logic [31:0] data);
        set_stb = 1'b1; set_addr = addr; set_data = data;
        wait_clk(1);
        set_stb = 1'b0;
        wait_clk(2);
    endtask

    // Master in mode 0: drive mosi while sclk low, capture miso as sclk rises.
    task automatic frame(input string tag, input int nb_cfg, input int nclk,
                         input logic [63:0] data, input int tx_at,
                         input logic [31:0] tx_new, input int rst_at);
        int eff, rx0, idx;
        logic [31:0] tx_cur, cap, exp_cap, mask;
        eff = (nb_cfg == 0) ? 32 : nb_cfg;
        tx_cur = tx_pend; cap = 0; exp_cap = 0; rx0 = rx_cnt;
        sen = 1'b0;
        wait_clk(8);
        check({tag, "_busy_on"}, 32'(busy), 32'd1);
        check({tag, "_oe_on"}, 32'(miso_oe), 32'd1);
        for (int i = 0; i < nclk; i++) begin
            mosi = data[nclk-1-i];
            wait_clk(4);
            if (i == tx_at) begin
                write_reg(TX_OFF, tx_new);
                tx_pend = tx_new;
            end
            if (i == rst_at) begin
                reset = 1'b1; sen = 1'b1;
                wait_clk(1);
                check({tag, "_rst_oe"}, 32'(miso_oe), 32'd0);
                check({tag, "_rst_busy"}, 32'(busy), 32'd0);
                reset = 1'b0;
                wait_clk(6);
                exp_rb = 32'd0; exp_err = 1'b0; tx_pend = 32'd0;
                check({tag, "_rst_rxstb"}, 32'(rx_cnt - rx0), 32'd0);
                check({tag, "_rst_rb"}, readback, exp_rb);
                check({tag, "_rst_err"}, 32'(error), 32'(exp_err));
                return;
            end
            wait_clk(4);
            sclk = 1'b1;
            idx = (i < eff) ? i : eff - 1;
            cap = {cap[30:0], miso};
            exp_cap = {exp_cap[30:0], tx_cur[31-idx]};
            wait_clk(8);
            sclk = 1'b0;
        end
        wait_clk(8);
        sen = 1'b1;
        wait_clk(8);
        mask = (eff == 32) ? 32'hFFFF_FFFF : ((32'd1 << eff) - 32'd1);
        if (nclk == eff) exp_rb = data[31:0] & mask;
        else             exp_err = 1'b1;
        check({tag, "_miso"}, cap, exp_cap);
        check({tag, "_rb"}, readback, exp_rb);
        check({tag, "_err"}, 32'(error), 32'(exp_err));
        check({tag, "_rxstb"}, 32'(rx_cnt - rx0), (nclk == eff) ? 32'd1 : 32'd0);
        check({tag, "_busy_off"}, 32'(busy), 32'd0);
        check({tag, "_oe_off"}, 32'(miso_oe), 32'd0);
    endtask

    task automatic clear_err(input string tag, input int nb_cfg);
        write_reg(CFG_OFF, 32'h140 | 32'(nb_cfg));
        exp_err = 1'b0;
        check({tag, "_clr"}, 32'(error), 32'd0);
    endtask

    initial begin
        int nb, nclk, pick;
        logic [31:0] txr;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(1);
        check("rst_rb", readback, 32'd0);
        check("rst_rxstb", 32'(rx_stb), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(error), 32'd0);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_oe", 32'(miso_oe), 32'd0);
`ifdef SIMPLE_SPI_SLAVE_DEBUG_EN
        check("rst_dbg_pad", {30'd0, debug[31:30]}, 32'd0);
`else
        check("rst_dbg", debug, 32'd0);
`endif

        write_reg(CFG_OFF, 32'h48);
        write_reg(TX_OFF, 32'hA500_0000); tx_pend = 32'hA500_0000;
        frame("m0_8", 8, 8, 64'h3C, -1, 0, -1);

        write_reg(CFG_OFF, 32'h40);
        write_reg(TX_OFF, 32'hDEAD_BEEF); tx_pend = 32'hDEAD_BEEF;
        frame("w32", 0, 32, 64'h1234_5678, -1, 0, -1);

        write_reg(CFG_OFF, 32'h50);
        frame("short", 16, 9, 64'h1FF, -1, 0, -1);
        clear_err("short", 16);

        write_reg(CFG_OFF, 32'h48);
        frame("long", 8, 10, 64'h2A5, -1, 0, -1);
        clear_err("long", 8);

        frame("nosclk", 8, 0, 64'h0, -1, 0, -1);
        clear_err("nosclk", 8);

        write_reg(TX_OFF, 32'h0); tx_pend = 32'h0;
        frame("txmid", 8, 8, 64'h81, 3, 32'hFFFF_FFFF, -1);
        frame("txnext", 8, 8, 64'h7E, -1, 0, -1);

        frame("rstmid", 8, 8, 64'h55, -1, 0, 4);
        write_reg(CFG_OFF, 32'h48);
        write_reg(TX_OFF, 32'hC300_0000); tx_pend = 32'hC300_0000;
        frame("postrst", 8, 8, 64'hE7, -1, 0, -1);

        for (int k = 0; k < 8; k++) begin
            nb = $urandom_range(1, 32);
            pick = $urandom_range(0, 3);
            nclk = (pick == 0) ? nb + 1 : (pick == 1) ? nb - 1 : nb;
            txr = $urandom;
            write_reg(CFG_OFF, 32'h40 | 32'((nb == 32) ? 0 : nb));
            write_reg(TX_OFF, txr); tx_pend = txr;
            frame($sformatf("rnd%0d", k), (nb == 32) ? 0 : nb, nclk,
                  {$urandom, $urandom}, -1, 0, -1);
            if (exp_err) clear_err($sformatf("rnd%0d", k), (nb == 32) ? 0 : nb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
